// File: rtl/smac_seq_ctrl.sv
// Bit-serial SMAC lane sequencer: pair k loads 1+(P+1)k cycles after start, result valid after 1+(P+1)len; hold stalls LOAD/BITS, result held until res_ready.
// Optional macro SMAC_ZERO_SKIP_EN: zero weight words are consumed in one LOAD cycle without entering BITS.
module smac_seq_ctrl #(
    parameter int Pw = 8,
    parameter int VW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              par_sel_Pw,
    input  logic [VW-1:0]           vec_len,
    input  logic                    in_valid,
    input  logic                    in_w_zero,
    output logic                    in_ready,
    input  logic                    hold,
    output logic                    w_load,
    output logic                    w_cnt,
    output logic                    cnt_clear,
    output logic                    acc_clear,
    output logic                    acc_en,
    output logic                    bit_msb,
    output logic [$clog2(Pw)-1:0]   bit_idx,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    done
);
    localparam int BW = $clog2(Pw);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BITS, S_RESULT} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_pm1;
    logic [BW-1:0]   r_bit_idx;
    logic [VW-1:0]   r_len;
    logic [VW-1:0]   r_elem_cnt;
    logic            r_done;

    logic            w_start_ok;
    logic            w_pair_hs;
    logic            w_skip;
    logic            w_last_elem;
    logic            w_last_bit;
    logic            w_bit_step;
    logic            w_res_hs;

    assign w_start_ok  = (r_state == S_IDLE) && start && (vec_len != '0);
    assign w_pair_hs   = (r_state == S_LOAD) && in_valid && !hold;
    assign w_last_elem = (r_elem_cnt == r_len - VW'(1));
    assign w_last_bit  = (r_bit_idx == r_pm1);
    assign w_bit_step  = (r_state == S_BITS) && !hold;
    assign w_res_hs    = (r_state == S_RESULT) && res_ready;

`ifdef SMAC_ZERO_SKIP_EN
    assign w_skip = w_pair_hs && in_w_zero;
`else
    logic w_unused_zero;
    assign w_unused_zero = in_w_zero;
    assign w_skip        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pm1      <= '0;
            r_bit_idx  <= '0;
            r_len      <= '0;
            r_elem_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_res_hs;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        // Codes 10 and 11 both select full 8-bit precision
                        case (par_sel_Pw)
                            2'b00:   r_pm1 <= BW'(3);
                            2'b01:   r_pm1 <= BW'(5);
                            default: r_pm1 <= BW'(7);
                        endcase
                        r_len      <= vec_len;
                        r_elem_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_pair_hs) begin
                        if (w_skip) begin
                            if (w_last_elem) r_state <= S_RESULT;
                            else             r_elem_cnt <= r_elem_cnt + VW'(1);
                        end else begin
                            r_bit_idx <= '0;
                            r_state   <= S_BITS;
                        end
                    end
                end
                S_BITS: begin
                    if (w_bit_step) begin
                        if (w_last_bit) begin
                            r_bit_idx <= '0;
                            if (w_last_elem) begin
                                r_state <= S_RESULT;
                            end else begin
                                r_elem_cnt <= r_elem_cnt + VW'(1);
                                r_state    <= S_LOAD;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end
                end
                S_RESULT: begin
                    if (res_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD) && !hold;
    assign w_load    = w_pair_hs && !w_skip;
    assign w_cnt     = w_bit_step;
    assign acc_en    = w_bit_step;
    assign bit_msb   = w_bit_step && w_last_bit;
    assign bit_idx   = r_bit_idx;
    assign acc_clear = w_start_ok;
    assign cnt_clear = w_start_ok || w_res_hs;
    assign res_valid = (r_state == S_RESULT);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Scoreboard bench for smac_seq_ctrl: stimulus pushes expected strobe events with cycle stamps, a negedge monitor pops and compares.
module tb_smac_seq_ctrl;
    localparam int VW = 8;
    localparam int EV_LOAD = 0, EV_MSB = 1, EV_RES = 2, EV_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    par_sel_Pw = 2'b00;
    logic [VW-1:0] vec_len = '0;
    logic          in_valid = 1'b0;
    logic          in_w_zero = 1'b0;
    logic          in_ready;
    logic          hold = 1'b0;
    logic          w_load, w_cnt, cnt_clear, acc_clear, acc_en, bit_msb;
    logic [2:0]    bit_idx;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          busy, done;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  acc_cnt = 0;
    logic res_prev = 1'b0;

    smac_seq_ctrl #(.Pw(8), .VW(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .par_sel_Pw(par_sel_Pw), .vec_len(vec_len),
        .in_valid(in_valid), .in_w_zero(in_w_zero), .in_ready(in_ready), .hold(hold),
        .w_load(w_load), .w_cnt(w_cnt), .cnt_clear(cnt_clear), .acc_clear(acc_clear),
        .acc_en(acc_en), .bit_msb(bit_msb), .bit_idx(bit_idx), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int idx);
        ev_t e;
        e.kind = kind; e.cyc = c; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int idx);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d (nothing expected)", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.idx != idx) begin
                failures++;
                $display("FAIL event got kind=%0d cycle=%0d idx=%0d expected kind=%0d cycle=%0d idx=%0d",
                         kind, cyc, idx, e.kind, e.cyc, e.idx);
            end
        end
    endtask

    always @(negedge clk) begin
        if (acc_en) acc_cnt++;
        if (w_load) check_ev(EV_LOAD, 0);
        if (bit_msb) check_ev(EV_MSB, int'(bit_idx));
        if (res_valid && !res_prev) check_ev(EV_RES, 0);
        if (done) check_ev(EV_DONE, 0);
        res_prev = res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Uninterrupted job: in_valid=1, hold=0, res_ready=1; zk names a zero-weight pair (-1 for none)
    task automatic run_job(input logic [1:0] psel, input int len, input int zk);
        int p, t, r, zcyc, exp_acc;
        p = (psel == 2'b00) ? 4 : (psel == 2'b01) ? 6 : 8;
        t = cyc + 1;
        zcyc = -1;
        exp_acc = 0;
        for (int k = 0; k < len; k++) begin
            if (k == zk) zcyc = t;
`ifdef SMAC_ZERO_SKIP_EN
            if (k == zk) begin
                t += 1;
                continue;
            end
`endif
            push(EV_LOAD, t, 0);
            push(EV_MSB, t + p, p - 1);
            exp_acc += p;
            t += p + 1;
        end
        r = t;
        push(EV_RES, r, 0);
        push(EV_DONE, r + 1, 0);
        acc_cnt = 0;
        par_sel_Pw = psel; vec_len = VW'(len);
        in_valid = 1'b1; hold = 1'b0; res_ready = 1'b1; start = 1'b1;
        while (cyc < r + 2) begin
            tick();
            start = 1'b0;
            in_w_zero = (cyc == zcyc);
        end
        in_w_zero = 1'b0;
        chk("acc_en_count", acc_cnt, exp_acc);
        chk("idle_after_job", int'(busy), 0);
    endtask

    initial begin
        int t0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_strobes", int'({w_load, w_cnt, acc_en, bit_msb, cnt_clear, acc_clear, done}), 0);
        chk("rst_bit_idx", int'(bit_idx), 0);

        tick();
        start = 1'b1; vec_len = '0; par_sel_Pw = 2'b10;
        #1;
        chk("len0_no_acc_clear", int'(acc_clear), 0);
        tick();
        start = 1'b0;
        #1;
        chk("len0_busy", int'(busy), 0);
        chk("len0_in_ready", int'(in_ready), 0);

        tick();
        run_job(2'b10, 4, -1);
        run_job(2'b00, 2, -1);
        run_job(2'b01, 1, -1);
        run_job(2'b11, 1, -1);

        // Stalls: in_valid low 3 LOAD cycles, hold 2 BITS cycles, res_ready low 4 cycles, start while busy
        t0 = cyc;
        push(EV_LOAD, t0 + 4, 0);
        push(EV_MSB, t0 + 14, 7);
        push(EV_RES, t0 + 15, 0);
        push(EV_DONE, t0 + 20, 0);
        acc_cnt = 0;
        start = 1'b1; par_sel_Pw = 2'b10; vec_len = 8'd1;
        in_valid = 1'b0; hold = 1'b0; res_ready = 1'b0;
        #1;
        chk("start_acc_clear", int'(acc_clear), 1);
        chk("start_cnt_clear", int'(cnt_clear), 1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            start = (i == 16);
            vec_len = (i == 16) ? 8'd5 : 8'd1;
            in_valid = (i >= 4);
            hold = (i == 7 || i == 8);
            res_ready = (i == 19);
            #1;
            if (i == 2) chk("load_wait_in_ready", int'(in_ready), 1);
            if (i == 7 || i == 8) begin
                chk("hold_bit_idx", int'(bit_idx), 2);
                chk("hold_no_acc_en", int'(acc_en), 0);
            end
            if (i >= 15 && i <= 19) chk("res_valid_held", int'(res_valid), 1);
            if (i == 16) chk("start_busy_ignored", int'(acc_clear), 0);
            if (i == 19) chk("res_hs_cnt_clear", int'(cnt_clear), 1);
            if (i == 20) chk("after_hs_busy", int'(busy), 0);
        end
        tick();
        start = 1'b0; res_ready = 1'b1;
        #1;
        chk("done_single_pulse", int'(done), 0);
        chk("stall_acc_en_count", acc_cnt, 8);

        // Reset in the middle of BITS abandons the job without done
        t0 = cyc;
        push(EV_LOAD, t0 + 1, 0);
        start = 1'b1; par_sel_Pw = 2'b10; vec_len = 8'd2; in_valid = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_strobes", int'({in_ready, w_load, w_cnt, acc_en, bit_msb, cnt_clear, acc_clear, res_valid, done}), 0);
        chk("midrst_bit_idx", int'(bit_idx), 0);
        repeat (3) tick();
        chk("midrst_stays_idle", int'(busy), 0);

        run_job(2'b10, 4, 1);
        run_job(2'b00, 255, -1);

        repeat (2) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
